// File: rtl/sw_btn_debounce.sv
// Debounces a slide switch and a push button: per-channel 2-flop synchronizer
// feeding a four-state accept/reject FSM with registered level and edge pulses.

module sw_btn_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHECK_HI,
    STABLE_HI,
    CHECK_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q;
  logic             sync_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  // NOTE: sequential state uses non-blocking assignments so sync_q takes the
  // old meta_q; a blocking '=' here would collapse the two flops into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (sync_q) begin
            state_q <= CHECK_HI;
            cnt_q   <= '0;
          end
        end
        CHECK_HI: begin
          if (!sync_q) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync_q) begin
            state_q <= CHECK_LO;
            cnt_q   <= '0;
          end
        end
        CHECK_LO: begin
          if (sync_q) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

module sw_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  input  logic btn_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  sw_btn_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_chan (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (sw_raw),
    .level_o(sw_level),
    .rise_o (sw_rise),
    .fall_o (sw_fall)
  );

  sw_btn_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_chan (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (btn_raw),
    .level_o(btn_level),
    .rise_o (btn_press),
    .fall_o (btn_release)
  );

endmodule

// File: doc/sw_btn_debounce.md
SW_BTN_DEBOUNCE -- requirements
Module: sw_btn_debounce

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- DEBOUNCE_CYCLES, 250000, number of consecutive stable cycles required to accept a new input level; legal range >= 2.
- CNT_W, 18, counter width; SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, input, 1, single system clock; all logic rising-edge.
- rst, input, 1, reset; asynchronous, active-high.
- sw_raw, input, 1, asynchronous slide-switch level.
- btn_raw, input, 1, asynchronous push-button level; 1 = pressed.
- sw_level, output, 1, debounced switch level.
- sw_rise, output, 1, one-cycle pulse on accepted sw 0->1.
- sw_fall, output, 1, one-cycle pulse on accepted sw 1->0.
- btn_level, output, 1, debounced button level.
- btn_press, output, 1, one-cycle pulse on accepted btn 0->1.
- btn_release, output, 1, one-cycle pulse on accepted btn 1->0.

Function
REQ-003 Each raw input SHALL pass through its own 2-flop synchronizer; only the second flop output (sync) SHALL feed downstream logic.
REQ-004 Each channel SHALL contain an independent FSM with states STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO and a CNT_W-bit counter.
REQ-005 STABLE_LO: sync=1 -> CHECK_HI, counter cleared to 0. Otherwise hold.
REQ-006 CHECK_HI: sync=0 -> STABLE_LO, counter cleared, with no output change (bounce rejected). sync=1 with counter /= DEBOUNCE_CYCLES-1 -> counter increments. sync=1 with counter = DEBOUNCE_CYCLES-1 -> STABLE_HI, level set to 1, rise/press pulse asserted for that one cycle.
REQ-007 STABLE_HI and CHECK_LO SHALL mirror REQ-005/REQ-006 with polarity inverted; acceptance clears level and asserts fall/release for one cycle.
REQ-008 Latency: if raw changes and is first sampled at edge k, and stays stable, level and pulse SHALL change at edge k+DEBOUNCE_CYCLES+2 exactly.
REQ-009 Any raw glitch that keeps the new value for fewer than DEBOUNCE_CYCLES+1 consecutive sync samples SHALL produce no output change.
REQ-010 Pulses SHALL be exactly one clock wide. At most one pulse per channel per cycle. Rise and fall SHALL never be asserted together.
REQ-011 Channels SHALL be fully independent. Simultaneous acceptance on both channels SHALL produce pulses in the same cycle.
REQ-012 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-013 Level outputs and pulse outputs SHALL be registered, with no combinational path from raw inputs.

Reset
REQ-014 While rst=1, all of the following SHALL be 0: synchronizer flops, counters, all outputs. Both FSMs SHALL be in STABLE_LO.
REQ-015 rst asserted mid-CHECK SHALL abort the check immediately, with no pulse emitted.
REQ-016 After rst release with a raw input held at 1, the channel SHALL perform a full debounce. It SHALL then assert level=1 with a single rise/press pulse at the REQ-008 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-017 Reset, then btn_raw 0->1 first sampled at edge k and held: btn_level=1 and btn_press=1 at edge k+6 only; btn_press=0 at k+7.
REQ-018 btn_raw high for 3 cycles, then low: btn_level stays 0, with no press/release pulse ever.
REQ-019 sw_raw toggling every cycle for 20 cycles, then held 1: exactly one sw_rise, 6 edges after the final stable sample begins, with no sw_fall.
REQ-020 sw_raw and btn_raw rise on the same edge: sw_rise and btn_press asserted in the same cycle.
REQ-021 rst pulsed while btn is in CHECK_HI (counter=2): all outputs 0; no pulse appears; with btn_raw held, press occurs 6 edges after release.
REQ-022 After a stable high, btn_raw 1->0 held: btn_release pulse and btn_level=0 after 6 edges; btn_press stays 0 throughout.
